// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control, data and status bundle for the universal shift register.
interface univ_shift_reg_if #(parameter int WIDTH = 8);
   localparam int CW = $clog2(WIDTH) + 1;
   logic             load_en;
   logic [WIDTH-1:0] load_val;
   logic             en;
   logic             dir;
   logic             rotate;
   logic             ser_in;
   logic             start;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] op;
   logic             ser_out;
   logic             busy;
   logic             done;
   modport master (output load_en, load_val, en, dir, rotate, ser_in, start, count,
                   input op, ser_out, busy, done);
   modport slave  (input load_en, load_val, en, dir, rotate, ser_in, start, count,
                   output op, ser_out, busy, done);
endinterface

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: load/shift/rotate register with a counted burst mode.
module univ_shift_reg #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input logic clk,
   input logic rstn,
   univ_shift_reg_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   typedef enum logic {IDLE, BUSY} state_t;
   state_t           state;
   logic [WIDTH-1:0] op_q, shifted;
   logic [CW-1:0]    rem;
   logic             ser_q, done_q, l_dir, l_rot, s_dir, s_rot, dep, fill;
   // A running burst uses its latched direction/mode; free-running shifts use live inputs.
   always_comb begin
      s_dir   = (state == BUSY) ? l_dir : bus.dir;
      s_rot   = (state == BUSY) ? l_rot : bus.rotate;
      dep     = s_dir ? op_q[0] : op_q[WIDTH-1];
      fill    = s_rot ? dep : bus.ser_in;
      shifted = s_dir ? {fill, op_q[WIDTH-1:1]} : {op_q[WIDTH-2:0], fill};
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state  <= IDLE;
         op_q   <= RST_VAL;
         ser_q  <= 1'b0;
         done_q <= 1'b0;
         rem    <= '0;
         l_dir  <= 1'b0;
         l_rot  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.load_en) begin
            op_q  <= bus.load_val;
            state <= IDLE;
         end else if (state == BUSY) begin
            op_q  <= shifted;
            ser_q <= dep;
            rem   <= rem - 1'b1;
            if (rem == CW'(1)) begin
               state  <= IDLE;
               done_q <= 1'b1;
            end
         end else if (bus.start) begin
            if (bus.count == '0) begin
               done_q <= 1'b1;
            end else begin
               state <= BUSY;
               rem   <= bus.count;
               l_dir <= bus.dir;
               l_rot <= bus.rotate;
            end
         end else if (bus.en) begin
            op_q  <= shifted;
            ser_q <= dep;
         end
      end
   end
   assign bus.op      = op_q;
   assign bus.ser_out = ser_q;
   assign bus.busy    = (state == BUSY);
   assign bus.done    = done_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed literal checks plus randomized traffic against a behavioural model.
module tb_univ_shift_reg;
   localparam int W = 8;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   passed = 0;
   int   total = 0;
   univ_shift_reg_if #(.WIDTH(W)) bus();
   univ_shift_reg #(.WIDTH(W), .RST_VAL(8'h00)) dut (.clk(clk), .rstn(rstn), .bus(bus));
   always #5 clk = ~clk;
   // behavioural model state: register value, last departed bit, shifts still owed
   int mop = 0, mser = 0, mdone = 0, mrem = 0, mdir = 0, mrot = 0;
   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask
   task automatic mshift(input int d, input int r);
      int dep, fl;
      dep  = d ? (mop % 2) : (mop / (1 << (W - 1)));
      fl   = r ? dep : int'(bus.ser_in);
      mop  = d ? (mop / 2 + fl * (1 << (W - 1))) : ((mop * 2 + fl) % (1 << W));
      mser = dep;
   endtask
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mop = 0; mser = 0; mdone = 0; mrem = 0;
      end else begin
         mdone = 0;
         if (bus.load_en) begin
            mop  = int'(bus.load_val);
            mrem = 0;
         end else if (mrem > 0) begin
            mshift(mdir, mrot);
            mrem--;
            if (mrem == 0) mdone = 1;
         end else if (bus.start) begin
            if (bus.count == 0) mdone = 1;
            else begin
               mrem = int'(bus.count); mdir = int'(bus.dir); mrot = int'(bus.rotate);
            end
         end else if (bus.en) mshift(int'(bus.dir), int'(bus.rotate));
      end
   end
   always @(negedge clk) begin
      chk("op", int'(bus.op), mop);
      chk("ser_out", int'(bus.ser_out), mser);
      chk("busy", int'(bus.busy), int'(mrem > 0));
      chk("done", int'(bus.done), mdone);
   end
   task automatic cyc();
      @(negedge clk);
   endtask
   task automatic idle_in();
      bus.load_en = 0; bus.load_val = '0; bus.en = 0; bus.dir = 0;
      bus.rotate = 0; bus.ser_in = 0; bus.start = 0; bus.count = '0;
   endtask
   logic [7:0] rot_exp [9] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
   logic [7:0] fil_exp [9] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'hFF};
   initial begin
      idle_in();
      cyc(); cyc();
      rstn = 1'b1;
      cyc();
      chk("rst_op", int'(bus.op), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      // walking one rotated left
      bus.load_en = 1; bus.load_val = 8'h01; cyc();
      chk("load01", int'(bus.op), 8'h01);
      bus.load_en = 0; bus.en = 1; bus.dir = 0; bus.rotate = 1;
      for (int i = 0; i < 9; i++) begin
         cyc();
         chk("rotl_op", int'(bus.op), int'(rot_exp[i]));
         if (i == 7) chk("rotl_ser", int'(bus.ser_out), 1);
      end
      // right shift filling with ones
      bus.en = 0; bus.load_en = 1; bus.load_val = 8'h00; cyc();
      bus.load_en = 0; bus.en = 1; bus.dir = 1; bus.rotate = 0; bus.ser_in = 1;
      for (int i = 0; i < 9; i++) begin
         cyc();
         chk("shr_op", int'(bus.op), int'(fil_exp[i]));
         chk("shr_ser", int'(bus.ser_out), (i == 8) ? 1 : 0);
      end
      // counted burst of 3
      idle_in(); bus.load_en = 1; bus.load_val = 8'h81; cyc();
      bus.load_en = 0; bus.start = 1; bus.count = 3; bus.dir = 0; bus.rotate = 1; cyc();
      chk("b3_acc_op", int'(bus.op), 8'h81);
      chk("b3_acc_busy", int'(bus.busy), 1);
      bus.start = 0; cyc();
      chk("b3_op1", int'(bus.op), 8'h03);
      cyc();
      chk("b3_op2", int'(bus.op), 8'h06);
      chk("b3_busy2", int'(bus.busy), 1);
      cyc();
      chk("b3_op3", int'(bus.op), 8'h0C);
      chk("b3_done", int'(bus.done), 1);
      chk("b3_busy3", int'(bus.busy), 0);
      cyc();
      chk("b3_done_gone", int'(bus.done), 0);
      // zero-length burst
      bus.start = 1; bus.count = 0; cyc();
      chk("b0_done", int'(bus.done), 1);
      chk("b0_busy", int'(bus.busy), 0);
      chk("b0_op", int'(bus.op), 8'h0C);
      bus.start = 0; cyc();
      chk("b0_done_gone", int'(bus.done), 0);
      // load aborts a burst
      bus.start = 1; bus.count = 5; cyc();
      bus.start = 0; cyc();
      chk("ab_op1", int'(bus.op), 8'h18);
      bus.load_en = 1; bus.load_val = 8'hA5; cyc();
      chk("ab_op", int'(bus.op), 8'hA5);
      chk("ab_busy", int'(bus.busy), 0);
      chk("ab_done", int'(bus.done), 0);
      bus.load_en = 0; cyc();
      chk("ab_no_done", int'(bus.done), 0);
      // asynchronous reset mid-burst
      bus.start = 1; bus.count = 5; cyc();
      bus.start = 0; cyc();
      #2 rstn = 1'b0;
      #1;
      chk("ar_op", int'(bus.op), 0);
      chk("ar_busy", int'(bus.busy), 0);
      chk("ar_done", int'(bus.done), 0);
      cyc();
      rstn = 1'b1;
      bus.start = 1; bus.count = 2; bus.dir = 1; bus.rotate = 0; bus.ser_in = 1; cyc();
      chk("ar_restart_busy", int'(bus.busy), 1);
      bus.start = 0; cyc(); cyc();
      chk("ar_restart_op", int'(bus.op), 8'hC0);
      chk("ar_restart_done", int'(bus.done), 1);
      // randomized traffic, including back-to-back starts and long bursts
      for (int i = 0; i < 3000; i++) begin
         bus.load_en  = ($urandom % 24) == 0;
         bus.load_val = 8'($urandom);
         bus.en       = 1'($urandom);
         bus.dir      = 1'($urandom);
         bus.rotate   = 1'($urandom);
         bus.ser_in   = 1'($urandom);
         bus.start    = ($urandom % 3) == 0;
         bus.count    = 4'($urandom_range(0, 15));
         if (($urandom % 250) == 0) begin
            #2 rstn = 1'b0;
            #1 rstn = 1'b1;
         end
         cyc();
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (minimum 2).
REQ-002 Parameter RST_VAL, default 0, value of op after reset.
REQ-003 Derived constant CW = $clog2(WIDTH)+1, width of the count port.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 load_en  input  1  parallel-load strobe.
REQ-007 load_val  input  WIDTH  parallel-load data.
REQ-008 en  input  1  free-running shift enable, one shift per cycle while high.
REQ-009 dir  input  1  shift direction: 0 = left (toward MSB), 1 = right.
REQ-010 rotate  input  1  1 = rotate (vacated bit takes the departing bit), 0 = shift (vacated bit takes ser_in).
REQ-011 ser_in  input  1  serial fill bit for shift mode.
REQ-012 start  input  1  request a burst of count shifts.
REQ-013 count  input  CW  burst length.
REQ-014 op  output  WIDTH  register contents (registered).
REQ-015 ser_out  output  1  last bit shifted or rotated out (registered).
REQ-016 busy  output  1  burst in progress.
REQ-017 done  output  1  one-cycle pulse on burst completion.

Function
REQ-018 The priority per edge SHALL be: load_en, then burst (start or BUSY), then en, then hold.
REQ-019 load_en=1 SHALL set op=load_val on the edge and leave ser_out unchanged.
REQ-020 A left shift SHALL give op={op[WIDTH-2:0], fill} with departing bit op[WIDTH-1]; a right shift SHALL give op={fill, op[WIDTH-1:1]} with departing bit op[0].
REQ-021 fill SHALL be the departing bit when rotating and ser_in when shifting; ser_out SHALL take the departing bit on every shift and hold otherwise.
REQ-022 The FSM SHALL have two states, IDLE and BUSY; busy=1 exactly in BUSY.
REQ-023 In IDLE, start=1 with load_en=0 and count=N>0 SHALL latch N, dir and rotate on edge T and enter BUSY; no shift occurs on edge T.
REQ-024 In BUSY, edges T+1..T+N SHALL each perform one shift using the latched dir and rotate and the live ser_in.
REQ-025 Edge T+N SHALL return the FSM to IDLE and raise done for exactly one cycle, coinciding with the final op value.
REQ-026 start with count=0 in IDLE SHALL pulse done in the next cycle, with no shift and busy staying 0.
REQ-027 start while BUSY SHALL be ignored; en SHALL be ignored while BUSY or while start is accepted.
REQ-028 load_en while BUSY SHALL load op, abort the burst to IDLE, and produce no done pulse.
REQ-029 A new start SHALL be accepted on the cycle done is high (back-to-back bursts).
REQ-030 count is unsigned; N > WIDTH SHALL perform N shifts with natural wrap-around.

Reset
REQ-031 rstn=0 SHALL immediately force op=RST_VAL, ser_out=0, busy=0, done=0 and the FSM to IDLE, independent of clk.
REQ-032 Release of rstn SHALL take effect at the next rising edge; assertion mid-burst SHALL discard the burst.

Verification (WIDTH=8, RST_VAL=0)
REQ-033 Load 8'h01, then en=1, dir=0, rotate=1 for 9 cycles -> op=02,04,08,10,20,40,80,01,02; ser_out=1 after the 80->01 edge.
REQ-034 Load 8'h00, then en=1, dir=1, rotate=0, ser_in=1 -> op=80,C0,E0,F0,...,FF; ser_out stays 0 until the ninth shift.
REQ-035 Load 8'h81, then start with count=3, dir=0, rotate=1 -> op=03,06,0C; busy high for 3 cycles after acceptance; done pulses once with op=0C.
REQ-036 start with count=0 -> done high one cycle later, op unchanged, busy never high.
REQ-037 Burst of count=5; load_en with load_val=8'hA5 at the second shift -> op=A5, busy=0 next cycle, no done pulse.
REQ-038 rstn driven low between clock edges mid-burst -> op=00, busy=0, done=0 immediately; after release, the FSM is IDLE and accepts a new start.
